// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO.
//
// Buffers a stream of DATA_W-bit words between blocks on one clock. The FIFO has
// almost-full and almost-empty thresholds, sticky overflow/underflow error flags,
// a synchronous flush, and either a registered read or a first-word-fall-through
// (FWFT) read.
//
// Parameters:
//   DATA_W     word width
//   DEPTH      number of entries (power of 2, >= 4)
//   AF_THRESH  almost_full when fifo_counter >= AF_THRESH
//   AE_THRESH  almost_empty when fifo_counter <= AE_THRESH
//   FWFT       0: buf_out is registered on each accepted read
//              1: buf_out shows the head word combinationally
//
// Ports:
//   clk, rst_n    clock (rising edge); asynchronous active-low reset
//   flush         synchronous clear of contents and error flags, beats wr_en/rd_en
//   wr_en, buf_in write request and data
//   rd_en         read request (FWFT: acknowledge/pop the head)
//   buf_out       read data; buf_valid marks it valid
//   buf_empty, buf_full, almost_empty, almost_full   status decoded from fifo_counter
//   fifo_counter  number of stored entries, 0..DEPTH
//   overflow      sticky: a write was rejected because the FIFO was full
//   underflow     sticky: a read was rejected because the FIFO was empty
module fifo_sync_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 12,
    parameter int unsigned AE_THRESH = 2,
    parameter bit          FWFT      = 1'b0,
    localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] buf_out,
    output logic              buf_valid,
    output logic              buf_empty,
    output logic              buf_full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [CW-1:0]     fifo_counter,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned PW = CW - 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_accept, rd_accept;

    // Status flags decode from the registered count, so they move on the count edge.
    assign buf_empty    = (count_q == CW'(0));
    assign buf_full     = (count_q == CW'(DEPTH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign fifo_counter = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        rd_accept   = rd_en & ~buf_empty;
        // A full FIFO can still take a write if a read frees a slot on the same edge.
        wr_accept   = wr_en & (~buf_full | rd_accept);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            // DEPTH is a power of 2, so pointers wrap DEPTH-1 -> 0 naturally.
            if (wr_accept) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_accept) rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wr_en && !wr_accept) overflow_d  = 1'b1;
            if (rd_en && !rd_accept) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept && !flush) begin
            mem[wr_ptr_q] <= buf_in;
        end
    end

    if (FWFT) begin : g_fwft
        // Head word shown directly; forced to zero when empty so reset/flush read as 0.
        assign buf_out   = buf_empty ? '0 : mem[rd_ptr_q];
        assign buf_valid = ~buf_empty;
    end else begin : g_std
        logic [DATA_W-1:0] out_q;
        logic              valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q   <= '0;
                valid_q <= 1'b0;
            end else if (flush) begin
                out_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                // One-cycle valid pulse per accepted read; data holds between reads.
                valid_q <= rd_accept;
                if (rd_accept) out_q <= mem[rd_ptr_q];
            end
        end

        assign buf_out   = out_q;
        assign buf_valid = valid_q;
    end

endmodule
